// File: rtl/bus_burst_responder.sv
// Burst-bus target backed by a word-wide synchronous SRAM.
// It answers reads and writes aimed at its address window and drives 0 on the bus whenever it is idle.
module bus_burst_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int unsigned WINDOW_WORDS = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned BUSY_PERIOD  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic        readNotWriteIn,
  input  logic [7:0]  burstSizeIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut,
  output logic        busyOut
);

  localparam int unsigned AW       = $clog2(WINDOW_WORDS);
  localparam int unsigned SW       = ((AW > 8) ? AW : 8) + 1;
  localparam int unsigned WaitLast = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;

  typedef enum logic [2:0] {StIdle, StRdWait, StRdData, StRdEnd, StWrData, StError} state_e;

  state_e         stateQ, stateD;
  logic [AW-1:0]  indexQ, indexD;
  logic [7:0]     countQ, countD;
  logic [15:0]    waitQ, waitD;
  logic [3:0]     beQ, beD;
  logic           wrDoneQ, wrDoneD;
  logic [15:0]    acceptCntQ, acceptCntD;

  logic [31:0]    mem [WINDOW_WORDS];

  logic           windowHit;
  logic [AW-1:0]  hdrIndex;
  logic [SW-1:0]  endSum;
  logic           hdrBad;
  logic           readFire;
  logic [AW-1:0]  rdAddr;
  logic           wrAccept;
  logic           wrEnable;
  logic           busyHit;
  logic           dataValidD, endTransactionD, busErrorD, busyD;

  assign windowHit = addressDataIn[31:AW+2] == BASE_ADDRESS[31:AW+2];
  assign hdrIndex  = addressDataIn[AW+1:2];
  assign endSum    = SW'(hdrIndex) + SW'(burstSizeIn);
  assign hdrBad    = (addressDataIn[1:0] != 2'b00) || (endSum >= SW'(WINDOW_WORDS));

  // State register and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ            <= StIdle;
      indexQ            <= '0;
      countQ            <= '0;
      waitQ             <= '0;
      beQ               <= '0;
      wrDoneQ           <= 1'b0;
      acceptCntQ        <= '0;
      dataValidOut      <= 1'b0;
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
      busyOut           <= 1'b0;
    end else begin
      stateQ            <= stateD;
      indexQ            <= indexD;
      countQ            <= countD;
      waitQ             <= waitD;
      beQ               <= beD;
      wrDoneQ           <= wrDoneD;
      acceptCntQ        <= acceptCntD;
      dataValidOut      <= dataValidD;
      endTransactionOut <= endTransactionD;
      busErrorOut       <= busErrorD;
      busyOut           <= busyD;
    end
  end

  // Next-state logic.
  always_comb begin
    stateD     = stateQ;
    indexD     = indexQ;
    countD     = countQ;
    waitD      = waitQ;
    beD        = beQ;
    wrDoneD    = wrDoneQ;
    acceptCntD = acceptCntQ;
    wrAccept   = 1'b0;
    wrEnable   = 1'b0;
    busyHit    = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (beginTransactionIn && windowHit) begin
          indexD     = hdrIndex;
          countD     = burstSizeIn;
          beD        = byteEnablesIn;
          waitD      = '0;
          wrDoneD    = 1'b0;
          acceptCntD = '0;
          if (hdrBad)              stateD = StError;
          else if (!readNotWriteIn) stateD = StWrData;
          else if (READ_LATENCY <= 1) stateD = StRdData;
          else                     stateD = StRdWait;
        end
      end
      StRdWait: begin
        if (waitQ == 16'(WaitLast)) stateD = StRdData;
        else                        waitD  = waitQ + 16'd1;
      end
      StRdData: begin
        if (countQ == 8'd0) stateD = StRdEnd;
        else                countD = countQ - 8'd1;
      end
      StRdEnd:  stateD = StIdle;
      StError:  stateD = StIdle;
      StWrData: begin
        wrAccept = dataValidIn && !busyOut;
        if (wrAccept) begin
          // Words past the end of the burst are accepted but not written.
          if (!wrDoneQ) begin
            wrEnable = 1'b1;
            if (countQ == 8'd0) begin
              wrDoneD = 1'b1;
            end else begin
              countD = countQ - 8'd1;
              indexD = indexQ + AW'(1);
            end
          end
          if (BUSY_PERIOD != 0) begin
            if (acceptCntQ == 16'(BUSY_PERIOD - 1)) begin
              busyHit    = 1'b1;
              acceptCntD = '0;
            end else begin
              acceptCntD = acceptCntQ + 16'd1;
            end
          end
        end
        if (endTransactionIn) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase

    // Read address runs one cycle ahead of the registered data beat.
    rdAddr   = (stateQ == StIdle) ? hdrIndex : indexQ;
    readFire = (stateD == StRdData);
    if (readFire) indexD = rdAddr + AW'(1);
  end

  // Output logic: values the output registers take on the coming edge.
  always_comb begin
    dataValidD      = readFire;
    endTransactionD = (stateD == StRdEnd);
    busErrorD       = (stateD == StError);
    busyD           = busyHit && (stateD == StWrData);
  end

  always_ff @(posedge clock) begin
    if (wrEnable && !reset) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (beQ[lane]) mem[indexQ][8*lane +: 8] <= addressDataIn[8*lane +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !readFire) addressDataOut <= '0;
    else                    addressDataOut <= mem[rdAddr];
  end

endmodule

// File: tb/tb_bus_burst_responder.sv
// Directed bench for bus_burst_responder: writes, reads, window errors, misses, byte lanes,
// write stalls and reset mid-burst, each checked against hand-computed values.
module tb_bus_burst_responder;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic        readNotWriteIn;
  logic [7:0]  burstSizeIn;
  logic [3:0]  byteEnablesIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;
  logic        busyOut;

  int errors = 0;
  int checks = 0;
  logic [31:0] wrBuf [8];
  logic [31:0] rdBuf [8];

  bus_burst_responder #(
    .BASE_ADDRESS(BASE),
    .WINDOW_WORDS(1024),
    .READ_LATENCY(2),
    .BUSY_PERIOD (2)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .beginTransactionIn(beginTransactionIn),
    .addressDataIn     (addressDataIn),
    .readNotWriteIn    (readNotWriteIn),
    .burstSizeIn       (burstSizeIn),
    .byteEnablesIn     (byteEnablesIn),
    .dataValidIn       (dataValidIn),
    .endTransactionIn  (endTransactionIn),
    .addressDataOut    (addressDataOut),
    .dataValidOut      (dataValidOut),
    .endTransactionOut (endTransactionOut),
    .busErrorOut       (busErrorOut),
    .busyOut           (busyOut)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_ctl"}, {28'd0, dataValidOut, endTransactionOut, busErrorOut, busyOut}, 32'd0);
    check({tag, "_data"}, addressDataOut, 32'd0);
  endtask

  task automatic header(input logic [31:0] addr, input logic rnw, input logic [7:0] burst,
                        input logic [3:0] be);
    beginTransactionIn = 1'b1;
    addressDataIn      = addr;
    readNotWriteIn     = rnw;
    burstSizeIn        = burst;
    byteEnablesIn      = be;
    step();
    beginTransactionIn = 1'b0;
    addressDataIn      = '0;
    readNotWriteIn     = 1'b0;
    burstSizeIn        = '0;
    byteEnablesIn      = '0;
  endtask

  // Presents one word, holding it while the target stalls.
  task automatic sendWord(input logic [31:0] w);
    int guard = 0;
    addressDataIn = w;
    dataValidIn   = 1'b1;
    while (busyOut && guard < 8) begin
      step();
      guard++;
    end
    check("busy_release", {31'd0, busyOut}, 32'd0);
    step();
    dataValidIn   = 1'b0;
    addressDataIn = '0;
  endtask

  task automatic endWrite();
    endTransactionIn = 1'b1;
    step();
    endTransactionIn = 1'b0;
  endtask

  task automatic writeBurst(input logic [31:0] addr, input int n, input logic [3:0] be);
    header(addr, 1'b0, 8'(n - 1), be);
    check("wr_noerr", {31'd0, busErrorOut}, 32'd0);
    for (int i = 0; i < n; i++) sendWord(wrBuf[i]);
    endWrite();
  endtask

  task automatic readBurst(input logic [31:0] addr, input int burst);
    int guard = 0;
    header(addr, 1'b1, 8'(burst), 4'hF);
    while (!dataValidOut && guard < 20) begin
      step();
      guard++;
    end
    for (int i = 0; i <= burst; i++) begin
      check("rd_valid", {31'd0, dataValidOut}, 32'd1);
      rdBuf[i] = addressDataOut;
      step();
    end
    check("rd_end", {31'd0, endTransactionOut}, 32'd1);
    step();
  endtask

  initial begin
    reset              = 1'b1;
    beginTransactionIn = 1'b0;
    addressDataIn      = '0;
    readNotWriteIn     = 1'b0;
    burstSizeIn        = '0;
    byteEnablesIn      = '0;
    dataValidIn        = 1'b0;
    endTransactionIn   = 1'b0;
    repeat (3) step();
    checkIdle("reset");
    reset = 1'b0;
    step();

    // T1: three-word write (stall after the second word is absorbed by sendWord)
    wrBuf[0] = 32'd10; wrBuf[1] = 32'd20; wrBuf[2] = 32'd30;
    writeBurst(BASE, 3, 4'hF);
    checkIdle("t1_after");

    // T2: read back with exact beat timing
    header(BASE, 1'b1, 8'd2, 4'hF);
    check("t2_h1_dv", {31'd0, dataValidOut}, 32'd0);
    step();
    check("t2_h2_dv", {31'd0, dataValidOut}, 32'd1);
    check("t2_h2_data", addressDataOut, 32'd10);
    step();
    check("t2_h3_data", addressDataOut, 32'd20);
    check("t2_h3_end", {31'd0, endTransactionOut}, 32'd0);
    step();
    check("t2_h4_data", addressDataOut, 32'd30);
    step();
    check("t2_h5_end", {31'd0, endTransactionOut}, 32'd1);
    check("t2_h5_dv", {31'd0, dataValidOut}, 32'd0);
    check("t2_h5_data", addressDataOut, 32'd0);
    step();
    checkIdle("t2_h6");

    // T3: last two words are fine, one more crosses the window end
    wrBuf[0] = 32'h0000_00E0; wrBuf[1] = 32'h0000_00E1;
    writeBurst(BASE + 32'd1022 * 4, 2, 4'hF);
    header(BASE + 32'd1022 * 4, 1'b0, 8'd2, 4'hF);
    check("t3_err", {31'd0, busErrorOut}, 32'd1);
    dataValidIn   = 1'b1;
    addressDataIn = 32'hBAD0_BAD0;
    step();
    checkIdle("t3_err_once");
    step();
    dataValidIn   = 1'b0;
    addressDataIn = '0;
    readBurst(BASE + 32'd1022 * 4, 1);
    check("t3_keep0", rdBuf[0], 32'h0000_00E0);
    check("t3_keep1", rdBuf[1], 32'h0000_00E1);
    header(BASE + 32'd2, 1'b1, 8'd0, 4'hF);
    check("t3_misalign_err", {31'd0, busErrorOut}, 32'd1);
    check("t3_misalign_dv", {31'd0, dataValidOut}, 32'd0);
    step();
    checkIdle("t3_misalign_after");

    // T4: miss just below the window, then byte-lane write
    header(BASE - 32'd4, 1'b1, 8'd0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      checkIdle("t4_miss");
      step();
    end
    wrBuf[0] = 32'h1122_3344;
    writeBurst(BASE + 32'd20, 1, 4'hF);
    wrBuf[0] = 32'hAABB_CCDD;
    writeBurst(BASE + 32'd20, 1, 4'b0011);
    readBurst(BASE + 32'd20, 0);
    check("t4_be", rdBuf[0], 32'h1122_CCDD);

    // T5: six-word burst with stalls, seventh word must be dropped
    wrBuf[0] = 32'h5A5A_5A5A;
    writeBurst(BASE + 32'd14 * 4, 1, 4'hF);
    header(BASE + 32'd8 * 4, 1'b0, 8'd5, 4'hF);
    for (int i = 0; i < 7; i++) begin
      sendWord(32'h100 + 32'(i));
      check("t5_busy", {31'd0, busyOut}, (i == 1 || i == 3 || i == 5) ? 32'd1 : 32'd0);
    end
    endWrite();
    checkIdle("t5_after");
    readBurst(BASE + 32'd8 * 4, 6);
    for (int i = 0; i < 6; i++) check("t5_data", rdBuf[i], 32'h100 + 32'(i));
    check("t5_dropped", rdBuf[6], 32'h5A5A_5A5A);

    // T6: reset during a read, then re-read
    for (int i = 0; i < 4; i++) wrBuf[i] = 32'h600 + 32'(i);
    writeBurst(BASE + 32'd64, 4, 4'hF);
    header(BASE + 32'd64, 1'b1, 8'd3, 4'hF);
    step();
    check("t6_beat0", addressDataOut, 32'h600);
    step();
    check("t6_beat1", addressDataOut, 32'h601);
    reset = 1'b1;
    step();
    checkIdle("t6_reset");
    reset = 1'b0;
    step();
    checkIdle("t6_post");
    readBurst(BASE + 32'd64, 3);
    for (int i = 0; i < 4; i++) check("t6_data", rdBuf[i], 32'h600 + 32'(i));
    checkIdle("t6_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
